// File: rtl/id_ex_stage_pkg.sv
// Shared definitions for the ID/EX stage: register index width, the zero
// register, and the layout of the opaque control bundle carried to EX.
package id_ex_stage_pkg;

   localparam int unsigned REG_ADDR_W = 5;
   localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;

   // Control bundle layout (opaque to this stage, consumed by EX/MEM/WB).
   localparam int unsigned CTRL_W          = 8;
   localparam int unsigned CTRL_ALU_OP_LSB = 0;
   localparam int unsigned CTRL_ALU_OP_W   = 4;
   localparam int unsigned CTRL_ALU_SRC    = 4;
   localparam int unsigned CTRL_MEM_WRITE  = 5;
   localparam int unsigned CTRL_MEM_TO_REG = 6;

   // True when a pipeline write to wr_addr produces the value read at rd_addr.
   function automatic logic reg_match(input logic                  we,
                                      input logic [REG_ADDR_W-1:0] wr_addr,
                                      input logic [REG_ADDR_W-1:0] rd_addr);
      return we && (wr_addr == rd_addr) && (rd_addr != ZERO_REG);
   endfunction

endpackage

// File: rtl/id_ex_stage_fwd_mux.sv
// One EX operand: zero register, then EX/MEM, then MEM/WB, then held value.
module id_ex_stage_fwd_mux
   import id_ex_stage_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic [REG_ADDR_W-1:0] addr,
   input  logic [WIDTH-1:0]      held,
   input  logic                  mem_reg_write,
   input  logic [REG_ADDR_W-1:0] mem_rd_addr,
   input  logic [WIDTH-1:0]      mem_rd_data,
   input  logic                  wb_reg_write,
   input  logic [REG_ADDR_W-1:0] wb_rd_addr,
   input  logic [WIDTH-1:0]      wb_rd_data,
   output logic [WIDTH-1:0]      val
);

   // Priority select; the youngest producer (EX/MEM) wins over MEM/WB.
   always_comb begin
      val = held;
      if (addr == ZERO_REG) begin
         val = '0;
      end else if (reg_match(mem_reg_write, mem_rd_addr, addr)) begin
         val = mem_rd_data;
      end else if (reg_match(wb_reg_write, wb_rd_addr, addr)) begin
         val = wb_rd_data;
      end
   end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with WB capture bypass, EX operand forwarding,
// load-use bubble insertion, flush and EX back-pressure.
module id_ex_stage
   import id_ex_stage_pkg::*;
#(
   parameter int unsigned WIDTH  = 32,
   parameter int unsigned CTRL_W = id_ex_stage_pkg::CTRL_W
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  id_valid,
   input  logic [REG_ADDR_W-1:0] id_rs_addr,
   input  logic [REG_ADDR_W-1:0] id_rt_addr,
   input  logic [REG_ADDR_W-1:0] id_rd_addr,
   input  logic [WIDTH-1:0]      id_rs_data,
   input  logic [WIDTH-1:0]      id_rt_data,
   input  logic [WIDTH-1:0]      id_imm,
   input  logic                  id_reg_write,
   input  logic                  id_mem_read,
   input  logic [CTRL_W-1:0]     id_ctrl,
   input  logic                  flush,
   input  logic                  ex_stall,
   input  logic                  mem_reg_write,
   input  logic [REG_ADDR_W-1:0] mem_rd_addr,
   input  logic [WIDTH-1:0]      mem_rd_data,
   input  logic                  wb_reg_write,
   input  logic [REG_ADDR_W-1:0] wb_rd_addr,
   input  logic [WIDTH-1:0]      wb_rd_data,
   output logic                  stall_id,
   output logic                  ex_valid,
   output logic [WIDTH-1:0]      ex_rs_val,
   output logic [WIDTH-1:0]      ex_rt_val,
   output logic [WIDTH-1:0]      ex_imm,
   output logic [REG_ADDR_W-1:0] ex_rd_addr,
   output logic                  ex_reg_write,
   output logic                  ex_mem_read,
   output logic [CTRL_W-1:0]     ex_ctrl
);

   logic                  valid_q, valid_d;
   logic [REG_ADDR_W-1:0] rs_addr_q, rs_addr_d;
   logic [REG_ADDR_W-1:0] rt_addr_q, rt_addr_d;
   logic [REG_ADDR_W-1:0] rd_addr_q, rd_addr_d;
   logic [WIDTH-1:0]      rs_val_q, rs_val_d;
   logic [WIDTH-1:0]      rt_val_q, rt_val_d;
   logic [WIDTH-1:0]      imm_q, imm_d;
   logic                  reg_write_q, reg_write_d;
   logic                  mem_read_q, mem_read_d;
   logic [CTRL_W-1:0]     ctrl_q, ctrl_d;

   logic [WIDTH-1:0]      id_rs_cap, id_rt_cap;
   logic                  load_use;

   id_ex_stage_fwd_mux #(.WIDTH(WIDTH)) u_fwd_rs (
      .addr          (rs_addr_q),
      .held          (rs_val_q),
      .mem_reg_write (mem_reg_write),
      .mem_rd_addr   (mem_rd_addr),
      .mem_rd_data   (mem_rd_data),
      .wb_reg_write  (wb_reg_write),
      .wb_rd_addr    (wb_rd_addr),
      .wb_rd_data    (wb_rd_data),
      .val           (ex_rs_val)
   );

   id_ex_stage_fwd_mux #(.WIDTH(WIDTH)) u_fwd_rt (
      .addr          (rt_addr_q),
      .held          (rt_val_q),
      .mem_reg_write (mem_reg_write),
      .mem_rd_addr   (mem_rd_addr),
      .mem_rd_data   (mem_rd_data),
      .wb_reg_write  (wb_reg_write),
      .wb_rd_addr    (wb_rd_addr),
      .wb_rd_data    (wb_rd_data),
      .val           (ex_rt_val)
   );

   // ID capture: the register file write at this edge is not yet visible in its read data.
   always_comb begin
      id_rs_cap = id_rs_data;
      id_rt_cap = id_rt_data;
      if (id_rs_addr == ZERO_REG) begin
         id_rs_cap = '0;
      end else if (reg_match(wb_reg_write, wb_rd_addr, id_rs_addr)) begin
         id_rs_cap = wb_rd_data;
      end
      if (id_rt_addr == ZERO_REG) begin
         id_rt_cap = '0;
      end else if (reg_match(wb_reg_write, wb_rd_addr, id_rt_addr)) begin
         id_rt_cap = wb_rd_data;
      end
   end

   // Hazard detection and ID stall.
   always_comb begin
      load_use = id_valid && valid_q && mem_read_q && (rd_addr_q != ZERO_REG) &&
                 ((rd_addr_q == id_rs_addr) || (rd_addr_q == id_rt_addr));
      stall_id = ex_stall || (load_use && !flush);
   end

   // Slot next state: flush > ex_stall > load-use bubble > capture.
   always_comb begin
      valid_d     = valid_q;
      rs_addr_d   = rs_addr_q;
      rt_addr_d   = rt_addr_q;
      rd_addr_d   = rd_addr_q;
      rs_val_d    = rs_val_q;
      rt_val_d    = rt_val_q;
      imm_d       = imm_q;
      reg_write_d = reg_write_q;
      mem_read_d  = mem_read_q;
      ctrl_d      = ctrl_q;
      if (flush || (!ex_stall && load_use)) begin
         valid_d     = 1'b0;
         reg_write_d = 1'b0;
         mem_read_d  = 1'b0;
      end else if (ex_stall) begin
         // Re-latch forwarded operands so a result retiring from WB during the hold survives.
         rs_val_d = ex_rs_val;
         rt_val_d = ex_rt_val;
      end else begin
         valid_d     = id_valid;
         rs_addr_d   = id_rs_addr;
         rt_addr_d   = id_rt_addr;
         rd_addr_d   = id_rd_addr;
         rs_val_d    = id_rs_cap;
         rt_val_d    = id_rt_cap;
         imm_d       = id_imm;
         reg_write_d = id_reg_write && id_valid;
         mem_read_d  = id_mem_read && id_valid;
         ctrl_d      = id_ctrl;
      end
   end

   // Slot registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q     <= 1'b0;
         rs_addr_q   <= '0;
         rt_addr_q   <= '0;
         rd_addr_q   <= '0;
         rs_val_q    <= '0;
         rt_val_q    <= '0;
         imm_q       <= '0;
         reg_write_q <= 1'b0;
         mem_read_q  <= 1'b0;
         ctrl_q      <= '0;
      end else begin
         valid_q     <= valid_d;
         rs_addr_q   <= rs_addr_d;
         rt_addr_q   <= rt_addr_d;
         rd_addr_q   <= rd_addr_d;
         rs_val_q    <= rs_val_d;
         rt_val_q    <= rt_val_d;
         imm_q       <= imm_d;
         reg_write_q <= reg_write_d;
         mem_read_q  <= mem_read_d;
         ctrl_q      <= ctrl_d;
      end
   end

   assign ex_valid     = valid_q;
   assign ex_imm       = imm_q;
   assign ex_rd_addr   = rd_addr_q;
   assign ex_reg_write = reg_write_q && valid_q;
   assign ex_mem_read  = mem_read_q && valid_q;
   assign ex_ctrl      = ctrl_q;

endmodule
